clock_set_ctrl: RTL



---
 rtl/clock_pkg.sv | 20 ++
 rtl/btn_edge_sync.sv | 33 +++
 rtl/clock_set_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared state type, SET_STATE encodings and default timing constants
// for the digital-clock mode/time-set controller.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } clkState_t;

  localparam logic [1:0] RUN_ENC = 2'b01;
  localparam logic [1:0] SET_ENC = 2'b10;

  // Defaults assume a 10 Hz TICK
  localparam int DEF_TIMEOUT_TICKS = 300;
  localparam int DEF_REPEAT_DELAY  = 5;
  localparam int DEF_REPEAT_RATE   = 2;
  localparam int DEF_BLINK_DIV     = 5;

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser for an asynchronous debounced button level, followed
// by a registered rising-edge detector producing a one-CLK pulse.
module btn_edge_sync (
  input  logic CLK,
  input  logic RESET,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rise_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
    end
  end

  assign level_o = sync2_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Run/set mode controller: turns synchronised MODE/SEL/INC presses into counter
// strobes, blink enables and an inactivity timeout. Define AUTO_REPEAT_EN to build held-INC auto-repeat.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE   = DEF_REPEAT_RATE,
  parameter int BLINK_DIV     = DEF_BLINK_DIV
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TICK,
  input  logic       BTN_MODE,
  input  logic       BTN_SEL,
  input  logic       BTN_INC,
  output logic [1:0] SET_STATE,
  output logic       INC_HOUR,
  output logic       INC_MIN,
  output logic       SEC_CLR,
  output logic       BLINK_HOUR,
  output logic       BLINK_MIN
);

  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
  localparam int BL_W = $clog2(BLINK_DIV + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);
  localparam logic [TO_W-1:0] TO_FULL = TO_W'(TIMEOUT_TICKS);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_DIV - 1);

  logic modeRise, selRise, incRise;
  logic modeLevelUnused, selLevelUnused, incLevel;

  btn_edge_sync uModeSync (.CLK(CLK), .RESET(RESET), .btn_i(BTN_MODE), .level_o(modeLevelUnused), .rise_o(modeRise));
  btn_edge_sync uSelSync  (.CLK(CLK), .RESET(RESET), .btn_i(BTN_SEL),  .level_o(selLevelUnused),  .rise_o(selRise));
  btn_edge_sync uIncSync  (.CLK(CLK), .RESET(RESET), .btn_i(BTN_INC),  .level_o(incLevel),        .rise_o(incRise));

  clkState_t       state_q, state_d;
  logic [TO_W-1:0] timeout_q, timeout_d;
  logic [BL_W-1:0] blinkCnt_q, blinkCnt_d;
  logic            phase_q, phase_d;
  logic [1:0]      setState_q, setState_d;
  logic            incHour_q, incHour_d, incMin_q, incMin_d, secClr_q, secClr_d;
  logic            blinkHour_q, blinkHour_d, blinkMin_q, blinkMin_d;
  logic            exitSet, enterSet, strobe, anyEvent, repeatFire;

`ifdef AUTO_REPEAT_EN
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RP_W   = $clog2(RP_MAX + 1);
  localparam logic [RP_W-1:0] RP_FIRST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_NEXT  = RP_W'(REPEAT_RATE - 1);

  logic            repActive_q, repActive_d, repRepeating_q, repRepeating_d;
  logic [RP_W-1:0] repCnt_q, repCnt_d;

  assign repeatFire = repActive_q && incLevel && TICK &&
                      (repCnt_q == (repRepeating_q ? RP_NEXT : RP_FIRST));

  // Repeat is armed by a real INC strobe and dropped on release or any state change
  always_comb begin
    repActive_d    = repActive_q;
    repRepeating_d = repRepeating_q;
    repCnt_d       = repCnt_q;
    if (state_d == RUN || state_d != state_q || !incLevel) begin
      repActive_d    = 1'b0;
      repRepeating_d = 1'b0;
      repCnt_d       = '0;
    end else if (strobe && incRise) begin
      repActive_d    = 1'b1;
      repRepeating_d = 1'b0;
      repCnt_d       = '0;
    end else if (repeatFire) begin
      repRepeating_d = 1'b1;
      repCnt_d       = '0;
    end else if (repActive_q && TICK) begin
      repCnt_d = repCnt_q + 1'b1;
    end
  end
`else
  logic incLevelUnused;
  localparam int RepeatCfgUnused = REPEAT_DELAY + REPEAT_RATE;
  assign incLevelUnused = incLevel;
  assign repeatFire     = 1'b0;
`endif

  // Priority MODE > SEL > INC; losing edges in the same cycle are simply dropped
  always_comb begin
    state_d    = state_q;
    timeout_d  = timeout_q;
    blinkCnt_d = blinkCnt_q;
    phase_d    = phase_q;
    exitSet    = 1'b0;
    enterSet   = 1'b0;
    strobe     = 1'b0;
    anyEvent   = modeRise | selRise | incRise | repeatFire;
    case (state_q)
      RUN: begin
        if (modeRise) begin
          state_d  = SET_HOUR;
          enterSet = 1'b1;
        end
      end
      default: begin
        if (modeRise) exitSet = 1'b1;
        else if (selRise) state_d = (state_q == SET_HOUR) ? SET_MIN : SET_HOUR;
        else if (incRise || repeatFire) strobe = 1'b1;
        if (anyEvent) begin
          timeout_d = '0;
        end else if (TICK && timeout_q != TO_FULL) begin
          timeout_d = timeout_q + 1'b1;
          if (timeout_q == TO_LAST) exitSet = 1'b1;
        end
      end
    endcase
    if (enterSet) timeout_d = '0;
    if (exitSet) state_d = RUN;

    // Digits stay visible for a full blink period after entry or any increment
    if (state_d == RUN || enterSet || strobe) begin
      phase_d    = 1'b0;
      blinkCnt_d = '0;
    end else if (TICK) begin
      if (blinkCnt_q == BL_LAST) begin
        blinkCnt_d = '0;
        phase_d    = ~phase_q;
      end else begin
        blinkCnt_d = blinkCnt_q + 1'b1;
      end
    end

    setState_d  = (state_d == RUN) ? RUN_ENC : SET_ENC;
    incHour_d   = strobe && (state_q == SET_HOUR);
    incMin_d    = strobe && (state_q == SET_MIN);
    secClr_d    = exitSet;
    blinkHour_d = phase_d && (state_d == SET_HOUR);
    blinkMin_d  = phase_d && (state_d == SET_MIN);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= RUN;
      timeout_q      <= '0;
      blinkCnt_q     <= '0;
      phase_q        <= 1'b0;
      setState_q     <= RUN_ENC;
      incHour_q      <= 1'b0;
      incMin_q       <= 1'b0;
      secClr_q       <= 1'b0;
      blinkHour_q    <= 1'b0;
      blinkMin_q     <= 1'b0;
`ifdef AUTO_REPEAT_EN
      repActive_q    <= 1'b0;
      repRepeating_q <= 1'b0;
      repCnt_q       <= '0;
`endif
    end else begin
      state_q        <= state_d;
      timeout_q      <= timeout_d;
      blinkCnt_q     <= blinkCnt_d;
      phase_q        <= phase_d;
      setState_q     <= setState_d;
      incHour_q      <= incHour_d;
      incMin_q       <= incMin_d;
      secClr_q       <= secClr_d;
      blinkHour_q    <= blinkHour_d;
      blinkMin_q     <= blinkMin_d;
`ifdef AUTO_REPEAT_EN
      repActive_q    <= repActive_d;
      repRepeating_q <= repRepeating_d;
      repCnt_q       <= repCnt_d;
`endif
    end
  end

  assign SET_STATE  = setState_q;
  assign INC_HOUR   = incHour_q;
  assign INC_MIN    = incMin_q;
  assign SEC_CLR    = secClr_q;
  assign BLINK_HOUR = blinkHour_q;
  assign BLINK_MIN  = blinkMin_q;

endmodule
